nvdla_dbb_rd_bridge: RTL
========================

Name: nvdla_dbb_rd_bridge

Overview:
Read-side DBB bridge between the NVDLA primary memory interface and the PULP cluster TCDM. It accepts one NVDLA DBB read request (addr, len, id) at a time, fetches len+1 beats of MEMIF_WIDTH bits as sequential 32-bit TCDM reads, and returns the beats on the DBB read-data channel with id and last. It sits directly downstream of the NVDLA dbb read-request/read-data ports, alongside the write bridge, inside the HWPE wrapper.

Parameters:
MEMIF_WIDTH, 64, DBB data beat width in bits; a multiple of 32, range 32..512.
WORDS_PER_BEAT, MEMIF_WIDTH/32, derived localparam: TCDM words per beat.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
enable_i  in  1  when low no new request is accepted; an in-flight burst completes
rd_req_valid_i  in  1  DBB read request valid
rd_req_ready_o  out  1  request accepted when valid&ready
rd_req_addr_i  in  32  byte address of first beat
rd_req_len_i  in  4  beats minus one (1..16 beats)
rd_req_id_i  in  8  transaction id
rd_dat_valid_o  out  1  read beat valid
rd_dat_ready_i  in  1  NVDLA accepts beat
rd_dat_data_o  out  MEMIF_WIDTH  beat data, word 0 in bits [31:0]
rd_dat_last_o  out  1  final beat of burst
rd_dat_id_o  out  8  id echoed from request
tcdm_req_o  out  1  TCDM request
tcdm_gnt_i  in  1  TCDM grant
tcdm_add_o  out  32  TCDM word address
tcdm_wen_o  out  1  constant 1 (read)
tcdm_be_o  out  4  constant 4'hF
tcdm_data_o  out  32  constant 0
tcdm_r_valid_i  in  1  TCDM response valid
tcdm_r_data_i  in  32  TCDM response data
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse after last beat handshake

Behaviour:
- Reset (rst_i=1 at clk edge): state IDLE; counters, latched addr/len/id, beat buffer cleared; all outputs 0 except tcdm_wen_o=1, tcdm_be_o=4'hF. Reset mid-burst aborts it; no further beats, no done_o.
- States: IDLE, READ, WAIT_READ, DATA.
- IDLE: rd_req_ready_o = enable_i. On valid&ready latch addr with [1:0] forced to 0, len, id; clear beat_cnt and word_cnt; -> READ.
- READ: tcdm_req_o=1, tcdm_add_o = base + beat_cnt*(MEMIF_WIDTH/8) + word_cnt*4, modulo 2^32 (wrap permitted). req and addr held stable until tcdm_gnt_i; on gnt -> WAIT_READ.
- WAIT_READ: tcdm_req_o=0. On tcdm_r_valid_i store r_data into buffer slot word_cnt. If word_cnt==WORDS_PER_BEAT-1 -> DATA, word_cnt=0; else word_cnt++ -> READ. r_valid outside WAIT_READ is ignored.
- DATA: rd_dat_valid_o=1, data/id stable, last = (beat_cnt==len). On rd_dat_ready_i: if last -> IDLE with done_o=1 next cycle; else beat_cnt++ -> READ. valid never drops before ready.
- One TCDM transaction outstanding at most; no request in IDLE/WAIT_READ/DATA.
- Latency, zero-wait TCDM (gnt same cycle, r_valid next), MEMIF_WIDTH=64: accept at T0, req T1, r_valid T2, req T3, r_valid T4, rd_dat_valid T5; each further beat +5 cycles with ready held high.
- enable_i dropping mid-burst has no effect until IDLE is reached.
- rd_req_ready_o is 0 in every state but IDLE; back-to-back requests cost one IDLE cycle.

Decomposition:
- nvdla_package gains: state_dbb_rd_t enum (DBB_RD_IDLE, DBB_RD_READ, DBB_RD_WAIT_READ, DBB_RD_DATA); NVDLA_PRIMARY_MEMIF_WIDTH localparam default 64, used as MEMIF_WIDTH default; existing ctrl_dbb_req_t/flags_dbb_rdat_t used at the wrapper boundary.
- Single module, no sub-module; beat buffer is a WORDS_PER_BEAT x 32 register array inside.

Test Plan:
- addr=0x1000_0000, len=0, id=0x5A, zero-wait TCDM, ready=1 -> tcdm_add 0x1000_0000, 0x1000_0004; one beat at T5 with last=1, id=0x5A, data={w1,w0}; done_o at T6.
- len=3, addr=0x2000_0010 -> 8 TCDM reads at 0x2000_0010..0x2000_002C in order; 4 beats, last only on 4th.
- gnt delayed 3 cycles, r_valid delayed 2 -> tcdm_req/add stable until gnt; data correct; no duplicate requests.
- rd_dat_ready_i low 4 cycles on beat 1 of len=1 -> valid, data, id, last stable; no TCDM req during stall.
- addr=0xFFFF_FFF8, len=1 -> second beat addresses 0x0000_0000, 0x0000_0004 (wrap).
- rst_i asserted during WAIT_READ of beat 2 -> next cycle IDLE, all outputs reset values, no done_o; new request accepted immediately after.

Source files
------------

// File: rtl/nvdla_dbb_rd_bridge_pkg.sv
// Shared types and constants for the NVDLA DBB read bridge.
package nvdla_dbb_rd_bridge_pkg;

  // Default width of the NVDLA primary memory interface data beat.
  localparam int NVDLA_PRIMARY_MEMIF_WIDTH = 64;

  // Read bridge control states.
  typedef enum logic [1:0] {
    DBB_RD_IDLE      = 2'd0,
    DBB_RD_READ      = 2'd1,
    DBB_RD_WAIT_READ = 2'd2,
    DBB_RD_DATA      = 2'd3
  } state_dbb_rd_t;

  // Request and read-data flag bundles used at the wrapper boundary.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [7:0]  id;
  } ctrl_dbb_req_t;

  typedef struct packed {
    logic       last;
    logic [7:0] id;
  } flags_dbb_rdat_t;

  // Byte address of one TCDM word inside a burst; wraps modulo 2^32.
  function automatic logic [31:0] dbb_word_addr(input logic [31:0] base,
                                                input logic [31:0] beat,
                                                input logic [31:0] word,
                                                input logic [31:0] beat_bytes);
    return base + (beat * beat_bytes) + (word << 2);
  endfunction

endpackage

// File: rtl/nvdla_dbb_rd_bridge_if.sv
// DBB read request/data channels plus the TCDM master port of the read bridge.
interface nvdla_dbb_rd_bridge_if
  import nvdla_dbb_rd_bridge_pkg::*;
#(
  parameter int MEMIF_WIDTH = NVDLA_PRIMARY_MEMIF_WIDTH
) ();

  // DBB read request channel
  logic                   rd_req_valid_i;
  logic                   rd_req_ready_o;
  logic [31:0]            rd_req_addr_i;
  logic [3:0]             rd_req_len_i;
  logic [7:0]             rd_req_id_i;

  // DBB read data channel
  logic                   rd_dat_valid_o;
  logic                   rd_dat_ready_i;
  logic [MEMIF_WIDTH-1:0] rd_dat_data_o;
  logic                   rd_dat_last_o;
  logic [7:0]             rd_dat_id_o;

  // TCDM port
  logic                   tcdm_req_o;
  logic                   tcdm_gnt_i;
  logic [31:0]            tcdm_add_o;
  logic                   tcdm_wen_o;
  logic [3:0]             tcdm_be_o;
  logic [31:0]            tcdm_data_o;
  logic                   tcdm_r_valid_i;
  logic [31:0]            tcdm_r_data_i;

  // Bridge side: serves DBB reads, issues TCDM reads.
  modport slave (
    input  rd_req_valid_i, rd_req_addr_i, rd_req_len_i, rd_req_id_i,
    output rd_req_ready_o,
    output rd_dat_valid_o, rd_dat_data_o, rd_dat_last_o, rd_dat_id_o,
    input  rd_dat_ready_i,
    output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
    input  tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i
  );

  // Environment side: NVDLA read client and TCDM memory.
  modport master (
    output rd_req_valid_i, rd_req_addr_i, rd_req_len_i, rd_req_id_i,
    input  rd_req_ready_o,
    input  rd_dat_valid_o, rd_dat_data_o, rd_dat_last_o, rd_dat_id_o,
    output rd_dat_ready_i,
    input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
    output tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i
  );

endinterface

// File: rtl/nvdla_dbb_rd_bridge.sv
// NVDLA DBB read bridge: one burst at a time, each beat assembled from
// sequential 32-bit TCDM reads, then returned on the DBB read-data channel.
module nvdla_dbb_rd_bridge
  import nvdla_dbb_rd_bridge_pkg::*;
#(
  parameter int MEMIF_WIDTH = NVDLA_PRIMARY_MEMIF_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  nvdla_dbb_rd_bridge_if.slave  bus,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int WORDS_PER_BEAT = MEMIF_WIDTH / 32;
  localparam int WCNT_W         = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam int BEAT_BYTES     = MEMIF_WIDTH / 8;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_BEAT - 1);

  state_dbb_rd_t     state_r;
  state_dbb_rd_t     state_s;
  logic [31:0]       base_r;
  logic [3:0]        len_r;
  logic [7:0]        id_r;
  logic [3:0]        beat_cnt_r;
  logic [WCNT_W-1:0] word_cnt_r;
  logic [31:0]       beat_buf_r [WORDS_PER_BEAT];
  logic              done_r;

  logic              req_hs_s;
  logic              word_last_s;
  logic              beat_last_s;

  assign req_hs_s    = (state_r == DBB_RD_IDLE) && enable_i && bus.rd_req_valid_i;
  assign word_last_s = (word_cnt_r == WCNT_LAST);
  assign beat_last_s = (beat_cnt_r == len_r);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= DBB_RD_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      DBB_RD_IDLE: begin
        if (req_hs_s) state_s = DBB_RD_READ;
        else          state_s = DBB_RD_IDLE;
      end
      DBB_RD_READ: begin
        if (bus.tcdm_gnt_i) state_s = DBB_RD_WAIT_READ;
        else                state_s = DBB_RD_READ;
      end
      DBB_RD_WAIT_READ: begin
        if (bus.tcdm_r_valid_i) begin
          if (word_last_s) state_s = DBB_RD_DATA;
          else             state_s = DBB_RD_READ;
        end else begin
          state_s = DBB_RD_WAIT_READ;
        end
      end
      DBB_RD_DATA: begin
        if (bus.rd_dat_ready_i) begin
          if (beat_last_s) state_s = DBB_RD_IDLE;
          else             state_s = DBB_RD_READ;
        end else begin
          state_s = DBB_RD_DATA;
        end
      end
      default: state_s = DBB_RD_IDLE;
    endcase
  end

  // Request latch, beat/word counters, beat buffer and completion pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_r     <= 32'd0;
      len_r      <= 4'd0;
      id_r       <= 8'd0;
      beat_cnt_r <= 4'd0;
      word_cnt_r <= '0;
      done_r     <= 1'b0;
      for (int i = 0; i < WORDS_PER_BEAT; i++) beat_buf_r[i] <= 32'd0;
    end else begin
      done_r <= (state_r == DBB_RD_DATA) && bus.rd_dat_ready_i && beat_last_s;
      case (state_r)
        DBB_RD_IDLE: begin
          if (req_hs_s) begin
            // TCDM is word addressed: the byte offset is dropped.
            base_r     <= bus.rd_req_addr_i & 32'hFFFF_FFFC;
            len_r      <= bus.rd_req_len_i;
            id_r       <= bus.rd_req_id_i;
            beat_cnt_r <= 4'd0;
            word_cnt_r <= '0;
          end
        end
        DBB_RD_WAIT_READ: begin
          if (bus.tcdm_r_valid_i) begin
            beat_buf_r[word_cnt_r] <= bus.tcdm_r_data_i;
            if (word_last_s) word_cnt_r <= '0;
            else             word_cnt_r <= word_cnt_r + 1'b1;
          end
        end
        DBB_RD_DATA: begin
          if (bus.rd_dat_ready_i && !beat_last_s) beat_cnt_r <= beat_cnt_r + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Beat data packing: word 0 lands in the least significant lane.
  always_comb begin
    bus.rd_dat_data_o = '0;
    for (int i = 0; i < WORDS_PER_BEAT; i++) begin
      bus.rd_dat_data_o[i*32 +: 32] = beat_buf_r[i];
    end
  end

  // Ready is suppressed while reset is applied so nothing looks accepted.
  assign bus.rd_req_ready_o = (state_r == DBB_RD_IDLE) && enable_i && !rst_i;
  assign bus.rd_dat_valid_o = (state_r == DBB_RD_DATA);
  assign bus.rd_dat_last_o  = (state_r == DBB_RD_DATA) && beat_last_s;
  assign bus.rd_dat_id_o    = id_r;

  assign bus.tcdm_req_o  = (state_r == DBB_RD_READ);
  assign bus.tcdm_add_o  = dbb_word_addr(base_r, 32'(beat_cnt_r), 32'(word_cnt_r),
                                         32'(BEAT_BYTES));
  assign bus.tcdm_wen_o  = 1'b1;
  assign bus.tcdm_be_o   = 4'hF;
  assign bus.tcdm_data_o = 32'd0;

  assign busy_o = (state_r != DBB_RD_IDLE);
  assign done_o = done_r;

endmodule
